// File: rtl/n_pipe_addsub.sv
// Pipelined add/subtract: the WIDTH-bit operation is cut into STAGES chunks, one chunk per
// stage, with the inter-chunk carry registered and a single global stall for the whole pipe.
module n_pipe_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_1_i,
  input  logic [WIDTH-1:0] in_2_i,
  input  logic             carry_in_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int unsigned CHUNK = (STAGES == 0) ? WIDTH : WIDTH / STAGES;

  if ((STAGES == 0) || (WIDTH % STAGES != 0)) begin : g_bad_params
    $error("n_pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic adv;

  assign adv        = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Rem: operand bits still unresolved on entry to this stage.
    localparam int unsigned Rem = WIDTH - k * CHUNK;

    logic                   v_src;
    logic                   c_src;
    logic                   sub_src;
    logic [Rem-1:0]         a_src;
    logic [Rem-1:0]         b_src;
    logic [CHUNK-1:0]       b_eff;
    logic [CHUNK:0]         chunk_sum;
    logic [(k+1)*CHUNK-1:0] res_d;
    logic                   v_q;
    logic                   c_q;
    logic [(k+1)*CHUNK-1:0] res_q;

    if (k == 0) begin : g_first
      assign v_src   = in_valid_i;
      assign sub_src = sub_i;
      assign c_src   = sub_i | carry_in_i;
      assign a_src   = in_1_i;
      assign b_src   = in_2_i;
      assign res_d   = chunk_sum[CHUNK-1:0];
    end else begin : g_next
      assign v_src   = g_stage[k-1].v_q;
      assign sub_src = g_stage[k-1].g_fwd.sub_q;
      assign c_src   = g_stage[k-1].c_q;
      assign a_src   = g_stage[k-1].g_fwd.a_q;
      assign b_src   = g_stage[k-1].g_fwd.b_q;
      assign res_d   = {chunk_sum[CHUNK-1:0], g_stage[k-1].res_q};
    end

    assign b_eff     = sub_src ? ~b_src[CHUNK-1:0] : b_src[CHUNK-1:0];
    assign chunk_sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_eff} + {{CHUNK{1'b0}}, c_src};

    // Data registers load only for valid transactions so outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q <= v_src;
        if (v_src) begin
          c_q   <= chunk_sum[CHUNK];
          res_q <= res_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [Rem-CHUNK-1:0] a_q;
      logic [Rem-CHUNK-1:0] b_q;
      logic                 sub_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (adv && v_src) begin
          a_q   <= a_src[Rem-1:CHUNK];
          b_q   <= b_src[Rem-1:CHUNK];
          sub_q <= sub_src;
        end
      end
    end else begin : g_last
      logic c_msb;
      logic ovf_q;

      // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
      assign c_msb = chunk_sum[CHUNK-1] ^ a_src[CHUNK-1] ^ b_eff[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && v_src) begin
          ovf_q <= c_msb ^ chunk_sum[CHUNK];
        end
      end

      assign out_valid_o = v_q;
      assign sum_o       = res_q;
      assign carry_out_o = c_q;
      assign overflow_o  = ovf_q;
    end
  end

endmodule

// File: tb/tb_n_pipe_addsub.sv
// Bench for n_pipe_addsub: directed corner vectors, streaming with stalls, reset flush and
// random traffic checked against an arithmetic reference with a STAGES-deep slot model.
module tb_n_pipe_addsub;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } slot_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         carry_in;
  logic         sub;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;

  logic         rdy4, ov4, co4, of4;
  logic [W-1:0] s4;
  logic         rdy1, ov1, co1, of1;
  logic [W-1:0] s1;
  logic         rdy16, ov16, co16, of16;
  logic [W-1:0] s16;

  int    nvec = 0;
  int    nfail = 0;
  bit    accepted;
  slot_t pipe[S];

  always #5 clk = ~clk;

  n_pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .in_1_i(in_1), .in_2_i(in_2), .carry_in_i(carry_in), .sub_i(sub),
    .out_valid_o(ov4), .out_ready_i(out_ready), .sum_o(s4), .carry_out_o(co4),
    .overflow_o(of4)
  );

  n_pipe_addsub #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_1_i(in_1), .in_2_i(in_2), .carry_in_i(carry_in), .sub_i(sub),
    .out_valid_o(ov1), .out_ready_i(out_ready), .sum_o(s1), .carry_out_o(co1),
    .overflow_o(of1)
  );

  n_pipe_addsub #(.WIDTH(W), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy16),
    .in_1_i(in_1), .in_2_i(in_2), .carry_in_i(carry_in), .sub_i(sub),
    .out_valid_o(ov16), .out_ready_i(out_ready), .sum_o(s16), .carry_out_o(co16),
    .overflow_o(of16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Plain W-bit arithmetic: A + B + cin, or A - B as A + ~B + 1.
  function automatic slot_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sb);
    slot_t        r;
    logic [W-1:0] be;
    logic [W:0]   t;
    be  = sb ? ~b : b;
    t   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : cin)};
    r.v = 1'b1;
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < S; i++) pipe[i] = '0;
  endtask

  // One clock of dut4 against the model; inputs must already be driven.
  task automatic cycle();
    bit    adv;
    slot_t nw;
    #1;
    adv = out_ready || !pipe[S-1].v;
    chk("in_ready", 32'(rdy4), 32'(adv));
    accepted = in_valid && adv;
    nw   = ref_op(in_1, in_2, carry_in, sub);
    nw.v = accepted;
    @(posedge clk);
    #1;
    if (adv) begin
      for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nw;
    end
    chk("out_valid", 32'(ov4), 32'(pipe[S-1].v));
    if (pipe[S-1].v) begin
      chk("sum", 32'(s4), 32'(pipe[S-1].s));
      chk("carry_out", 32'(co4), 32'(pipe[S-1].c));
      chk("overflow", 32'(of4), 32'(pipe[S-1].o));
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sb);
    in_1     = a;
    in_2     = b;
    carry_in = cin;
    sub      = sb;
  endtask

  // Single transaction into an empty pipe; result expected exactly S cycles later.
  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sb, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    out_ready = 1'b1;
    drive(a, b, cin, sb);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 1; i < S; i++) cycle();
    chk({tag, "_valid"}, 32'(ov4), 32'd1);
    chk({tag, "_sum"}, 32'(s4), 32'(es));
    chk({tag, "_cout"}, 32'(co4), 32'(ec));
    chk({tag, "_ovf"}, 32'(of4), 32'(eo));
    cycle();
  endtask

  initial begin
    int           n;
    int           lat1;
    int           lat16;
    logic [W-1:0] r1, r16;
    logic         c1r, c16r, o1r, o16r;
    logic [W-1:0] corner[4];

    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h7FFF;
    corner[3] = 16'h8000;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_sum", 32'(s4), 32'd0);
    chk("rst_cout", 32'(co4), 32'd0);
    chk("rst_ovf", 32'(of4), 32'd0);
    chk("rst_in_ready", 32'(rdy4), 32'd1);
    rst_n = 1'b1;

    single("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("t2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("t2b", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    single("t3a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("t3b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Eight back-to-back inputs with the sink always ready.
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      in_valid = 1'b1;
      cycle();
      if (accepted) n++;
    end
    chk("t4_accepted", 32'(n), 32'd8);
    in_valid = 1'b0;
    repeat (S + 2) cycle();

    // Six inputs with the sink stalled for three cycles mid-stream.
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (!accepted || c == 0)
        ;
      drive(16'h1000 * 16'(n + 1) + 16'h0F0F, 16'h0123 * 16'(n + 3), 1'(n), 1'(n >> 1));
      in_valid  = 1'b1;
      out_ready = !(c >= 5 && c < 8);
      cycle();
      if (accepted) n++;
    end
    chk("t5_accepted", 32'(n), 32'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) cycle();

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(ov4), 32'd0);
    chk("t6_rst_in_ready", 32'(rdy4), 32'd1);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (S + 4) cycle();

    // Random traffic with corner operands mixed in.
    for (int i = 0; i < 400; i++) begin
      in_1 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      in_2 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      carry_in  = 1'($urandom);
      sub       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) cycle();

    // Test 1 again on the STAGES=1 and STAGES=16 instances.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat1  = -1;
    lat16 = -1;
    r1 = '0; r16 = '0; c1r = 1'b0; c16r = 1'b0; o1r = 1'b1; o16r = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ov1 && lat1 < 0) begin
        lat1 = e; r1 = s1; c1r = co1; o1r = of1;
      end
      if (ov16 && lat16 < 0) begin
        lat16 = e; r16 = s16; c16r = co16; o16r = of16;
      end
    end
    chk("s1_latency", 32'(lat1), 32'd1);
    chk("s1_sum", 32'(r1), 32'h0000);
    chk("s1_cout", 32'(c1r), 32'd1);
    chk("s1_ovf", 32'(o1r), 32'd0);
    chk("s16_latency", 32'(lat16), 32'd16);
    chk("s16_sum", 32'(r16), 32'h0000);
    chk("s16_cout", 32'(c16r), 32'd1);
    chk("s16_ovf", 32'(o16r), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
